// File: rtl/fifo_rd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_ctrl_pkg
//  Description : Shared defaults and FSM state encoding for the FIFO read-side
//                transmit controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_ctrl_pkg;

   localparam int unsigned C_DATA_WIDTH   = 8;
   localparam int unsigned C_BUSY_TIMEOUT = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_SEND      = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_WAIT_DONE = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ctrl_tmo_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tmo_counter
//  Description : Saturating acknowledge-timeout counter. o_tc flags the
//                enabled cycle whose increment brings the count to TERMINAL.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmo_counter #(
   parameter int unsigned TERMINAL = 32,
   parameter int unsigned WIDTH    = $clog2(TERMINAL + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [WIDTH-1:0] C_TERM = WIDTH'(TERMINAL);
   localparam logic [WIDTH-1:0] C_LAST = WIDTH'(TERMINAL - 1);

   logic [WIDTH-1:0] r_count;

   assign o_tc = i_en && (r_count == C_LAST);

   // Count enabled cycles; clear has priority and the count never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != C_TERM)) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_ctrl
//  Description : Pops words from a first-word-fall-through FIFO and hands them
//                to a serializer, one load strobe per word, with an
//                acknowledge timeout that re-sends the held word.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = C_DATA_WIDTH,
   parameter int unsigned BUSY_TIMEOUT = C_BUSY_TIMEOUT
) (
   input  logic                  R_CLK,
   input  logic                  R_RST,
   input  logic                  EMPTY,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  R_INC,
   input  logic                  TX_EN,
   input  logic                  TX_BUSY,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_DATA_VALID,
   output logic [15:0]           FRAME_CNT,
   output logic                  TMO_ERR
);

   state_t                r_state;
   state_t                w_next;
   logic                  w_tmo_clr;
   logic                  w_tmo_en;
   logic                  w_tmo_tc;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_tx_valid;
   logic [15:0]           r_frame_cnt;
   logic                  r_tmo_err;

   // The counter restarts on every SEND so each WAIT_ACK visit gets a full window.
   assign w_tmo_clr = (r_state == ST_SEND);
   assign w_tmo_en  = (r_state == ST_WAIT_ACK);

   tmo_counter #(
      .TERMINAL (BUSY_TIMEOUT)
   ) u_tmo_counter (
      .clk   (R_CLK),
      .rst   (R_RST),
      .i_clr (w_tmo_clr),
      .i_en  (w_tmo_en),
      .o_tc  (w_tmo_tc)
   );

   // Next-state decode; acknowledge wins over a coincident timeout.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:      if (TX_EN && !EMPTY && !TX_BUSY) w_next = ST_LOAD;
         ST_LOAD:      w_next = ST_SEND;
         ST_SEND:      w_next = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (TX_BUSY)       w_next = ST_WAIT_DONE;
            else if (w_tmo_tc) w_next = ST_SEND;
         end
         ST_WAIT_DONE: if (!TX_BUSY) w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge R_CLK) begin
      if (R_RST) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Registered outputs: data capture, load strobe, frame count, sticky timeout.
   always_ff @(posedge R_CLK) begin
      if (R_RST) begin
         r_tx_data   <= '0;
         r_tx_valid  <= 1'b0;
         r_frame_cnt <= '0;
         r_tmo_err   <= 1'b0;
      end else begin
         r_tx_valid <= (w_next == ST_SEND);
         if (r_state == ST_LOAD)
            r_tx_data <= RD_DATA;
         if ((r_state == ST_WAIT_DONE) && !TX_BUSY)
            r_frame_cnt <= r_frame_cnt + 16'd1;
         if ((r_state == ST_WAIT_ACK) && !TX_BUSY && w_tmo_tc)
            r_tmo_err <= 1'b1;
      end
   end

   // Pop strobe comes straight from the state register, one per LOAD visit.
   assign R_INC         = (r_state == ST_LOAD);
   assign TX_P_DATA     = r_tx_data;
   assign TX_DATA_VALID = r_tx_valid;
   assign FRAME_CNT     = r_frame_cnt;
   assign TMO_ERR       = r_tmo_err;

endmodule
`default_nettype wire

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; both are named below.
REQ-002 Parameter DATA_WIDTH SHALL default to 8 and set the payload width.
REQ-003 Parameter BUSY_TIMEOUT SHALL default to 32 and set the R_CLK cycles allowed for TX_BUSY to rise after TX_DATA_VALID.
REQ-004 Port R_CLK SHALL be an input of width 1: the read-domain clock.
REQ-005 Port R_RST SHALL be an input of width 1: synchronous, active-high reset.
REQ-006 Port EMPTY SHALL be an input of width 1: FIFO empty flag, already synchronised to R_CLK.
REQ-007 Port RD_DATA SHALL be an input of width DATA_WIDTH: FIFO head word, valid whenever EMPTY=0 (first-word-fall-through).
REQ-008 Port R_INC SHALL be an output of width 1: FIFO pop strobe.
REQ-009 Port TX_EN SHALL be an input of width 1: transmit enable.
REQ-010 Port TX_BUSY SHALL be an input of width 1: serializer busy.
REQ-011 Port TX_P_DATA SHALL be an output of width DATA_WIDTH: parallel byte to the serializer.
REQ-012 Port TX_DATA_VALID SHALL be an output of width 1: one-cycle load strobe.
REQ-013 Port FRAME_CNT SHALL be an output of width 16: count of completed transfers.
REQ-014 Port TMO_ERR SHALL be an output of width 1: sticky flag, set when a retry occurs.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, LOAD, SEND, WAIT_ACK and WAIT_DONE.
REQ-016 IDLE SHALL go to LOAD when TX_EN=1, EMPTY=0 and TX_BUSY=0; otherwise it SHALL stay in IDLE.
REQ-017 R_INC SHALL be 1 only in LOAD, decoded from the state register, so each transfer produces exactly one pop.
REQ-018 The LOAD clock edge SHALL capture RD_DATA into TX_P_DATA, and LOAD SHALL then go to SEND.
REQ-019 TX_DATA_VALID SHALL be 1 only while in SEND; SEND SHALL last one cycle and then go to WAIT_ACK.
REQ-020 The timing from the IDLE decision edge SHALL be: R_INC high in the next cycle, TX_DATA_VALID high in the cycle after that.
REQ-021 WAIT_ACK SHALL go to WAIT_DONE on TX_BUSY=1.
REQ-022 In WAIT_ACK, the timeout counter SHALL clear on entry and increment each cycle.
REQ-023 When the counter reaches BUSY_TIMEOUT, the block SHALL set TMO_ERR and return to SEND, re-sending the same TX_P_DATA with no new pop.
REQ-024 WAIT_DONE SHALL go to IDLE on TX_BUSY=0, incrementing FRAME_CNT by 1 in the same edge.
REQ-025 FRAME_CNT SHALL wrap from 0xFFFF to 0x0000.
REQ-026 TX_EN=0 outside IDLE SHALL NOT abort the current transfer; the block SHALL finish the transfer and then hold in IDLE.
REQ-027 EMPTY rising during LOAD..WAIT_DONE SHALL be ignored until the block returns to IDLE.
REQ-028 TX_BUSY=1 in IDLE SHALL block the start of a transfer.
REQ-029 TX_P_DATA SHALL hold its value from the LOAD edge until the next LOAD.
REQ-030 The timeout counter SHALL be clog2(BUSY_TIMEOUT+1) bits wide and SHALL NOT wrap.

Reset
REQ-031 When R_RST=1 at an R_CLK edge, the state SHALL become IDLE, TX_P_DATA 0, TX_DATA_VALID 0, R_INC 0, FRAME_CNT 0, TMO_ERR 0 and the timeout counter 0.
REQ-032 A reset asserted mid-transfer SHALL discard the in-flight byte, which SHALL NOT be re-popped, and SHALL NOT increment FRAME_CNT.
REQ-033 TMO_ERR SHALL clear only on R_RST.

Structure
REQ-034 The state encodings (3-bit binary: IDLE=0 .. WAIT_DONE=4) and the default parameters SHALL live in the shared system package.
REQ-035 The timeout counter SHALL be a single sub-module, tmo_counter, with clear, enable and terminal-count ports.
REQ-036 All outputs except R_INC SHALL be registered; R_INC SHALL be decoded from the state register with no input-to-output combinational path.

Verification
REQ-037 Reset, then FIFO holding 0x83, TX_EN=1, and a serializer model raising TX_BUSY 1 cycle after valid for 10 cycles -> exactly one R_INC pulse, TX_P_DATA=0x83, TX_DATA_VALID one cycle, FRAME_CNT=1.
REQ-038 FIFO holding 0x83, 0x86, 0x80, 0x84 -> four transfers in order, four R_INC pulses, FRAME_CNT=4, back in IDLE with EMPTY=1.
REQ-039 TX_BUSY held 0 for 40 cycles after valid -> TX_DATA_VALID re-pulses at cycle 32 with the same TX_P_DATA, TMO_ERR=1, and no extra R_INC.
REQ-040 TX_EN dropped during WAIT_ACK with 0x09 in flight -> 0x09 completes, FRAME_CNT increments, and no further LOAD occurs while TX_EN=0.
REQ-041 R_RST pulsed in WAIT_DONE -> all outputs 0 on the next edge, FRAME_CNT=0, and the next word after release is the following FIFO entry.
REQ-042 FRAME_CNT preloaded through 65535 transfers (forced) plus 1 -> FRAME_CNT=0x0000.
